// File: rtl/sar_search_ctrl_pkg.sv
// sar_search_ctrl_pkg
//   Shared definitions for the successive-approximation search controller:
//   FSM state encoding, the default operand width and the helper that sizes
//   the compare-step counter.
//
//   Optional feature macro used by sar_search_ctrl: SAR_EARLY_EXIT_EN.
package sar_search_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMP  = 2'd1,
    ST_DONE = 2'd2
  } sar_state_t;

  localparam int SAR_WIDTH_DEF = 4;

  // Step counter must hold the value WIDTH itself, hence the extra bit.
  function automatic int sar_steps_w(input int width);
    return $clog2(width) + 1;
  endfunction

  localparam int SAR_STEPS_W_DEF = sar_steps_w(SAR_WIDTH_DEF);

endpackage

// File: rtl/sar_search_ctrl_onehot_chk.sv
// sar_onehot_chk
//   Combinational sanity check on the magnitude-comparator outputs. A healthy
//   comparator drives exactly one of lt/gt/eq; anything else is flagged.
//
//   Ports:
//     a_lt_b, a_gt_b, a_eq_b  in   comparator result lines
//     not_onehot              out  1 when the three lines are not one-hot
module sar_onehot_chk (
  input  logic a_lt_b,
  input  logic a_gt_b,
  input  logic a_eq_b,
  output logic not_onehot
);

  always_comb begin
    not_onehot = 1'b1;
    case ({a_lt_b, a_gt_b, a_eq_b})
      3'b100,
      3'b010,
      3'b001:  not_onehot = 1'b0;
      default: not_onehot = 1'b1;
    endcase
  end

endmodule

// File: rtl/sar_search_ctrl.sv
// sar_search_ctrl
//   Successive-approximation search controller. Drives the B operand of a
//   combinational magnitude comparator and resolves the unknown value on its
//   A input one bit per clock, MSB first.
//
//   Build option: define SAR_EARLY_EXIT_EN to terminate a search as soon as
//   the comparator reports equality. Without it a search always takes WIDTH
//   compares (unless the comparator outputs are not one-hot).
//
//   State table:
//     ST_IDLE | waiting for start; outputs hold the last search's result
//     ST_CMP  | one compare per clock, guess driven to comparator B input
//     ST_DONE | one-cycle done pulse, guess back to 0
//
//   Ports:
//     clk      in   single clock, rising edge
//     rst      in   synchronous active-high reset
//     start    in   begin a search (only honoured in ST_IDLE)
//     a_lt_b   in   comparator: target < guess
//     a_gt_b   in   comparator: target > guess
//     a_eq_b   in   comparator: target == guess
//     guess    out  registered trial operand for comparator B
//     result   out  recovered target, held until the next accepted start
//     busy     out  high while compares are in progress
//     done     out  one-cycle pulse at search end
//     err      out  comparator lines were not one-hot during the search
//     steps    out  compares used by the last search
module sar_search_ctrl
  import sar_search_ctrl_pkg::*;
#(
  parameter  int WIDTH   = SAR_WIDTH_DEF,
  localparam int STEPS_W = sar_steps_w(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               a_lt_b,
  input  logic               a_gt_b,
  input  logic               a_eq_b,
  output logic [WIDTH-1:0]   guess,
  output logic [WIDTH-1:0]   result,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [STEPS_W-1:0] steps
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0]   MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0]   ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0]   IDX_TOP  = IDX_W'(WIDTH - 1);
  localparam logic [STEPS_W-1:0] STEP_ONE = STEPS_W'(1);

  sar_state_t       state_q, state_d;
  logic [WIDTH-1:0] trial_q, trial_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] guess_q, guess_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             err_q, err_d;
  logic [STEPS_W-1:0] steps_q, steps_d;

  logic             not_onehot;
  logic [WIDTH-1:0] bit_cur;
  logic [WIDTH-1:0] bit_next;
  logic [WIDTH-1:0] kept;
  logic             eq_exit;

  sar_onehot_chk u_onehot_chk (
    .a_lt_b     (a_lt_b),
    .a_gt_b     (a_gt_b),
    .a_eq_b     (a_eq_b),
    .not_onehot (not_onehot)
  );

  // bit_cur is the bit under test; bit_next is the one tried on the next
  // compare (zero when bit_cur is the LSB, but it is unused then).
  assign bit_cur  = ONE_W << idx_q;
  assign bit_next = bit_cur >> 1;
  assign kept     = a_lt_b ? (trial_q & ~bit_cur) : trial_q;

`ifdef SAR_EARLY_EXIT_EN
  assign eq_exit = a_eq_b;
`else
  assign eq_exit = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    trial_d  = trial_q;
    idx_d    = idx_q;
    guess_d  = guess_q;
    result_d = result_q;
    err_d    = err_q;
    steps_d  = steps_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          result_d = '0;
          err_d    = 1'b0;
          steps_d  = '0;
          trial_d  = MSB_ONLY;
          guess_d  = MSB_ONLY;
          idx_d    = IDX_TOP;
          state_d  = ST_CMP;
        end
      end

      ST_CMP: begin
        steps_d = steps_q + STEP_ONE;
        if (not_onehot) begin
          err_d    = 1'b1;
          result_d = '0;
          guess_d  = '0;
          state_d  = ST_DONE;
        end else if (eq_exit) begin
          // The current guess already matches the target.
          result_d = guess_q;
          guess_d  = '0;
          state_d  = ST_DONE;
        end else if (idx_q != '0) begin
          trial_d = kept | bit_next;
          guess_d = kept | bit_next;
          idx_d   = idx_q - IDX_W'(1);
        end else begin
          result_d = kept;
          guess_d  = '0;
          state_d  = ST_DONE;
        end
      end

      ST_DONE: begin
        guess_d = '0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        guess_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      trial_q  <= '0;
      idx_q    <= '0;
      guess_q  <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      steps_q  <= '0;
    end else begin
      state_q  <= state_d;
      trial_q  <= trial_d;
      idx_q    <= idx_d;
      guess_q  <= guess_d;
      result_q <= result_d;
      err_q    <= err_d;
      steps_q  <= steps_d;
    end
  end

  assign guess  = guess_q;
  assign result = result_q;
  assign busy   = (state_q == ST_CMP);
  assign done   = (state_q == ST_DONE);
  assign err    = err_q;
  assign steps  = steps_q;

endmodule

// File: tb/tb_sar_search_ctrl.sv
// tb_sar_search_ctrl
//   Self-checking bench: a behavioural comparator sits between a target
//   value and the controller's guess; expected guesses, result, step count
//   and latency come from a plain binary-search model.
module tb_sar_search_ctrl;

  localparam int W  = 4;
  localparam int SW = $clog2(W) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [W-1:0]  target = '0;
  logic          force_bad = 1'b0;
  logic          a_lt_b, a_gt_b, a_eq_b;
  logic [W-1:0]  guess, result;
  logic          busy, done, err;
  logic [SW-1:0] steps;

  int n_checks = 0;
  int n_errors = 0;

  int exp_guess[$];
  int exp_result;
  int exp_steps;
  int exp_err;

  always #5 clk = ~clk;

  // Stand-in for the gate-level comparator: target on A, guess on B.
  assign a_lt_b = force_bad ? 1'b1 : (target < guess);
  assign a_gt_b = force_bad ? 1'b1 : (target > guess);
  assign a_eq_b = force_bad ? 1'b0 : (target == guess);

  sar_search_ctrl #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a_lt_b (a_lt_b),
    .a_gt_b (a_gt_b),
    .a_eq_b (a_eq_b),
    .guess  (guess),
    .result (result),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .steps  (steps)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Binary search over [0, 2^W): try each bit from the top, keep it when the
  // target is at least the trial value.
  task automatic model(input int tgt, input bit bad_first);
    int acc;
    int g;
    exp_guess.delete();
    exp_err = 0;
    if (bad_first) begin
      exp_guess.push_back(1 << (W - 1));
      exp_result = 0;
      exp_steps  = 1;
      exp_err    = 1;
      return;
    end
    acc = 0;
    exp_steps = 0;
    exp_result = -1;
    for (int b = W - 1; b >= 0; b--) begin
      g = acc + (1 << b);
      exp_guess.push_back(g);
      exp_steps++;
`ifdef SAR_EARLY_EXIT_EN
      if (tgt == g) begin
        exp_result = g;
        break;
      end
`endif
      if (tgt >= g) acc = g;
    end
    if (exp_result < 0) exp_result = acc;
  endtask

  // One search from IDLE. rst_at > 0 pulses reset in that cycle after start.
  task automatic run_search(input int tgt, input bit bad_first,
                            input bit hold_start, input int rst_at);
    int cyc;
    int gi;
    target = W'(tgt);
    model(tgt, bad_first);
    start = 1'b1;
    @(posedge clk); #1;
    if (!hold_start) start = 1'b0;
    cyc = 1;
    gi  = 0;
    check("busy_after_start", busy, 1);
    check("err_cleared", err, 0);
    check("result_cleared", result, 0);
    while (cyc <= 20 && !done) begin
      if (rst_at == cyc) begin
        start = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_guess", guess, 0);
        check("rst_result", result, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_steps", steps, 0);
        @(posedge clk); #1;
        check("rst_idle", busy, 0);
        return;
      end
      force_bad = bad_first && (cyc == 1);
      if (busy) begin
        if (gi < exp_guess.size())
          check($sformatf("guess_t%0h_%0d", tgt, gi), guess, exp_guess[gi]);
        else
          check("guess_extra_compare", gi, exp_guess.size() - 1);
        gi++;
      end
      @(posedge clk); #1;
      force_bad = 1'b0;
      cyc++;
    end
    if (!done) begin
      check("done_timeout", done, 1);
      start = 1'b0;
      return;
    end
    check($sformatf("latency_t%0h", tgt), cyc, exp_steps + 1);
    check($sformatf("result_t%0h", tgt), result, exp_result);
    check($sformatf("steps_t%0h", tgt), steps, exp_steps);
    check($sformatf("err_t%0h", tgt), err, exp_err);
    check("busy_low_at_done", busy, 0);
    // start may still be high here; DONE must ignore it.
    @(posedge clk); #1;
    start = 1'b0;
    check("done_single_pulse", done, 0);
    check("guess_zero_after", guess, 0);
    check("busy_idle", busy, 0);
    @(posedge clk); #1;
    check("no_restart", busy, 0);
    check("result_held", result, exp_result);
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_guess", guess, 0);
    check("reset_result", result, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_err", err, 0);
    check("reset_steps", steps, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_search('hB, 1'b0, 1'b0, 0);
    run_search('h8, 1'b0, 1'b0, 0);
    run_search('h0, 1'b0, 1'b0, 0);
    run_search('hF, 1'b0, 1'b0, 0);
    run_search('h3, 1'b1, 1'b0, 0);
    run_search('h3, 1'b0, 1'b0, 0);
    run_search('hA, 1'b0, 1'b0, 2);
    run_search('h5, 1'b0, 1'b0, 0);
    run_search('h6, 1'b0, 1'b1, 0);
    for (int k = 0; k < 24; k++)
      run_search(int'($urandom_range(0, (1 << W) - 1)), 1'b0, k[2], 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/sar_search_ctrl.md
# sar_search_ctrl

Successive-approximation search controller that drives the B operand of the team's gate-level magnitude comparator and consumes its A_lt_B / A_gt_B / A_eq_B outputs. It recovers an unknown target value on the comparator's A input, one bit per clock, MSB first. It is the sequential counterpart that sits in front of the combinational comparator: this block generates the operand and interprets the result.

## Interface
- WIDTH, 4, operand width in bits; sets the guess/result width and the maximum step count.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a search; sampled only in IDLE.
- a_lt_b  input  1  comparator result: target < guess.
- a_gt_b  input  1  comparator result: target > guess.
- a_eq_b  input  1  comparator result: target == guess.
- guess  output  WIDTH  registered operand driven to the comparator B input.
- result  output  WIDTH  recovered target; held until the next accepted start.
- busy  output  1  high while comparisons are in progress.
- done  output  1  one-cycle pulse when the search ends.
- err  output  1  comparator inputs were not one-hot; held until the next accepted start.
- steps  output  clog2(WIDTH)+1  number of compare cycles used by the last search.

## Operation
- States: IDLE, CMP, DONE.
- IDLE, with start=1:
  - Clear result, err, and steps.
  - Load guess = 1 << (WIDTH-1) and bit index i = WIDTH-1.
  - Go to CMP.
- CMP: each edge samples the three compare inputs against the current guess and increments steps.
  - Not exactly one input high: set err=1, set result=0, go to DONE.
  - a_lt_b: clear bit i of the trial value.
  - a_gt_b or a_eq_b: keep bit i.
  - If i > 0: set bit i-1 in the new trial value, drive it on guess, decrement i.
  - If i == 0: result = final trial value, go to DONE.
- DONE: done=1 for one cycle, guess returns to 0, next state IDLE.
- Arithmetic is unsigned. The comparator is combinational, so exactly one cycle is spent per bit.
- start while busy or in DONE: ignored, with no queuing.
- rst at any time: IDLE, all outputs 0, search abandoned.
- Reset values: guess=0, result=0, busy=0, done=0, err=0, steps=0.

## Timing
- start sampled at edge E0. busy=1 and guess=MSB-only from cycle E0+1.
- Full search: compares at edges E1..EWIDTH. done and result valid in the cycle after EWIDTH, so latency is WIDTH+1 cycles from start.
- busy deasserts in the same cycle done asserts.
- err abort: done in the cycle after the offending edge. steps includes the erroring compare.
- A new start is accepted the cycle after done, i.e. in IDLE.

## Configuration
- SAR_EARLY_EXIT_EN defined: a_eq_b high in CMP ends the search immediately. result = current guess, go to DONE, steps = compares so far.
- SAR_EARLY_EXIT_EN undefined: a_eq_b is treated as "keep bit". Exactly WIDTH compares always occur unless err.

## Structure
- Shared package/include holds:
  - state encodings IDLE/CMP/DONE
  - the WIDTH default
  - the steps-width constant
- One sub-module, sar_onehot_chk: combinational check that flags when a_lt_b/a_gt_b/a_eq_b is not exactly one-hot.
- Datapath (trial value, bit index, steps) and the FSM stay in sar_search_ctrl.
- The bench wires the existing 4-bit comparator with the target on A and guess on B.

## Test plan
- Target 4'hB, early exit undefined: guesses 8,C,A,B; result=B, steps=4, done at start+5.
- Target 4'h8, SAR_EARLY_EXIT_EN defined: guess 8 gives eq; done at start+2, result=8, steps=1. Same target undefined: guesses 8,C,A,9; result=8, steps=4.
- Targets 4'h0 and 4'hF: guesses 8,4,2,1 → result 0; guesses 8,C,E,F → result F; steps=4 each.
- Force a_lt_b=a_gt_b=1 on the first compare: err=1, result=0, done at start+2, steps=1. err clears on the next start.
- rst asserted at start+2: next cycle all outputs 0, state IDLE. A fresh start with target 5 → result=5.
- start held high during a search: ignored; exactly one done pulse per accepted start.
